// File: rtl/calc_disp_pkg.sv
// calc_disp_pkg
// Shared constants for the calculator result display path.
//   - Digit codes: 0..9 are BCD digits, CODE_MINUS draws a minus sign,
//     CODE_BLANK (and any of 10..14) leaves the digit dark.
//   - Seven-segment glyphs, active low, ordered {g,f,e,d,c,b,a}.
//   - Anode enables, active low; bit 3 is the leftmost digit (D1).
package calc_disp_pkg;

    localparam logic [3:0] CODE_MINUS = 4'hF;
    localparam logic [3:0] CODE_BLANK = 4'hE;

    localparam logic [6:0] GLYPH_0     = 7'b1000000;
    localparam logic [6:0] GLYPH_1     = 7'b1111001;
    localparam logic [6:0] GLYPH_2     = 7'b0100100;
    localparam logic [6:0] GLYPH_3     = 7'b0110000;
    localparam logic [6:0] GLYPH_4     = 7'b0011001;
    localparam logic [6:0] GLYPH_5     = 7'b0010010;
    localparam logic [6:0] GLYPH_6     = 7'b0000010;
    localparam logic [6:0] GLYPH_7     = 7'b1111000;
    localparam logic [6:0] GLYPH_8     = 7'b0000000;
    localparam logic [6:0] GLYPH_9     = 7'b0010000;
    localparam logic [6:0] GLYPH_MINUS = 7'b0111111;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

    localparam logic [3:0] AN_D1  = 4'b0111;
    localparam logic [3:0] AN_D2  = 4'b1011;
    localparam logic [3:0] AN_D3  = 4'b1101;
    localparam logic [3:0] AN_D4  = 4'b1110;
    localparam logic [3:0] AN_OFF = 4'b1111;

    // Scan index 0 is the units digit (rightmost), index 3 the thousands.
    function automatic logic [3:0] anode_for_index(input logic [1:0] idx);
        logic [3:0] an;
        case (idx)
            2'd0:    an = AN_D4;
            2'd1:    an = AN_D3;
            2'd2:    an = AN_D2;
            default: an = AN_D1;
        endcase
        return an;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// seg7_decoder
// Combinational digit-code to seven-segment converter.
//   code : 4-bit digit code (0..9 digit, 4'hF minus, 10..14 blank)
//   seg  : active-low segments {g,f,e,d,c,b,a}
module seg7_decoder
    import calc_disp_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    always_comb begin
        seg = GLYPH_BLANK;
        case (code)
            4'd0:       seg = GLYPH_0;
            4'd1:       seg = GLYPH_1;
            4'd2:       seg = GLYPH_2;
            4'd3:       seg = GLYPH_3;
            4'd4:       seg = GLYPH_4;
            4'd5:       seg = GLYPH_5;
            4'd6:       seg = GLYPH_6;
            4'd7:       seg = GLYPH_7;
            4'd8:       seg = GLYPH_8;
            4'd9:       seg = GLYPH_9;
            CODE_MINUS: seg = GLYPH_MINUS;
            default:    seg = GLYPH_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_display_mux.sv
// seg_display_mux
// Latches a four-digit signed result and scans it onto a 4-digit
// common-anode seven-segment display.
//   clk, rst        : clock, synchronous active-high reset
//   load            : capture D1..D4 / isNegative on this edge
//   D1..D4          : digit codes, D1 = thousands (leftmost), D4 = units
//   isNegative      : result sign
//   anode           : active-low digit enables, bit 3 = D1, bit 0 = D4
//   seg             : active-low segments {g,f,e,d,c,b,a}
//   dp              : decimal point, always off (1)
// Each digit slot lasts DWELL cycles; the first cycle of every slot is dark
// to stop the previous digit ghosting onto the next anode.
module seg_display_mux
    import calc_disp_pkg::*;
#(
    parameter int DWELL         = 100000,
    parameter int BLANK_LEADING = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] D1,
    input  logic [3:0] D2,
    input  logic [3:0] D3,
    input  logic [3:0] D4,
    input  logic       isNegative,
    output logic [3:0] anode,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int CNT_W = $clog2(DWELL);

    logic [CNT_W-1:0] cnt_reg;
    logic [1:0]       idx_reg;
    logic [3:0]       shadow_reg [4];   // index 3 = D1 ... index 0 = D4
    logic             sign_reg;
    logic [3:0]       code_reg;         // resolved code of the slot being shown
    logic [3:0]       anode_reg;
    logic [6:0]       seg_reg;

    logic             slot_end;
    logic [1:0]       idx_next;
    logic [6:0]       seg_glyph;

    // Per-position resolution of the shadow value into display codes.
    logic [3:1]       zero;
    logic [3:1]       lead_zero;
    logic [3:0]       blank;
    logic [3:1]       minus;
    logic [3:0]       resolved [4];

    assign slot_end = (cnt_reg == CNT_W'(DWELL - 1));
    assign idx_next = idx_reg + 2'd1;

    // The units digit is never blanked and never takes the minus: the minus
    // always lands left of the most-significant displayed digit.
    assign blank[0]    = 1'b0;
    assign resolved[0] = shadow_reg[0];

    genvar gi;
    generate
        for (gi = 1; gi < 4; gi++) begin : g_pos
            assign zero[gi]      = (shadow_reg[gi] == 4'd0);
            assign lead_zero[gi] = &zero[3:gi];
            assign blank[gi]     = (BLANK_LEADING != 0) && lead_zero[gi];
            if (gi == 3) begin : g_top
                // Leftmost position: either the nearest blank slot, or it
                // overrides a significant D1 (accepted truncation).
                assign minus[gi] = sign_reg && (!blank[3] || !blank[2]);
            end else begin : g_mid
                assign minus[gi] = sign_reg && blank[gi] && !blank[gi-1];
            end
            assign resolved[gi] = minus[gi] ? CODE_MINUS :
                                  (blank[gi] ? CODE_BLANK : shadow_reg[gi]);
        end
    endgenerate

    seg7_decoder u_decoder (
        .code (code_reg),
        .seg  (seg_glyph)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                shadow_reg[i] <= 4'd0;
            end
            sign_reg  <= 1'b0;
            cnt_reg   <= '0;
            idx_reg   <= 2'd0;
            code_reg  <= CODE_BLANK;
            anode_reg <= AN_OFF;
            seg_reg   <= GLYPH_BLANK;
        end else begin
            if (load) begin
                shadow_reg[3] <= D1;
                shadow_reg[2] <= D2;
                shadow_reg[1] <= D3;
                shadow_reg[0] <= D4;
                sign_reg      <= isNegative;
            end

            cnt_reg <= slot_end ? '0 : cnt_reg + CNT_W'(1);

            // The next slot's code is frozen at the slot boundary, so a load
            // arriving mid-slot cannot change the glyph currently lit.
            if (slot_end) begin
                idx_reg  <= idx_next;
                code_reg <= resolved[idx_next];
            end

            if (cnt_reg == '0) begin
                anode_reg <= AN_OFF;
                seg_reg   <= GLYPH_BLANK;
            end else begin
                anode_reg <= anode_for_index(idx_reg);
                seg_reg   <= seg_glyph;
            end
        end
    end

    assign anode = anode_reg;
    assign seg   = seg_reg;
    assign dp    = 1'b1;

endmodule
